// File: rtl/aes_pkg.sv
// aes_pkg
// Shared constants and helpers for the AES round-tail datapath.
//   STATE_W  : width of the AES-128 state
//   RED_POLY : low byte of the GF(2^8) reduction polynomial 0x11B
//   xtime    : multiply a byte by {02} in GF(2^8)
//   byte_msb : MSB position of the state byte at (row, col); byte k sits at
//              [127-8k -: 8] with row k%4 and column k/4
package aes_pkg;

    localparam int STATE_W = 128;
    localparam logic [7:0] RED_POLY = 8'h1B;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        logic [7:0] red;
        if (b[7]) begin
            red = RED_POLY;
        end else begin
            red = 8'h00;
        end
        return {b[6:0], 1'b0} ^ red;
    endfunction

    function automatic int byte_msb(input int row, input int col);
        return 127 - 8 * (4 * col + row);
    endfunction

endpackage

// File: rtl/mix_column.sv
// mix_column
// Combinational MixColumns for one state column: multiplies the column by
// the {02,03,01,01} circulant matrix over GF(2^8).
//   col   : 32-bit input column, row 0 in [31:24]
//   mixed : 32-bit output column, same byte order
module mix_column
    import aes_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] mixed
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    // {03}*b is computed as xtime(b) ^ b
    assign mixed = {
        x0 ^ (x1 ^ a1) ^ a2 ^ a3,
        a0 ^ x1 ^ (x2 ^ a2) ^ a3,
        a0 ^ a1 ^ x2 ^ (x3 ^ a3),
        (x0 ^ a0) ^ a1 ^ a2 ^ x3
    };

endmodule

// File: rtl/aes_round_tail.sv
// aes_round_tail
// Registered AES-128 round tail: ShiftRows, MixColumns (bypassed when
// in_last is set) and AddRoundKey on one 128-bit state per beat, with
// valid/ready handshakes on both sides and full throughput.
// Optional build macro MIXCOL_PIPE_EN adds a register after
// ShiftRows/MixColumns (latency 2, holds 2 beats); default latency is 1.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_ready          : input handshake
//   in_data, in_key            : SubBytes output and round key
//   in_last, in_tag            : final-round flag and sideband tag
//   out_valid/out_ready        : output handshake
//   out_data, out_last, out_tag: registered result and sideband
module aes_round_tail
    import aes_pkg::*;
#(
    parameter int TAG_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_data,
    input  logic [127:0]       in_key,
    input  logic               in_last,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_data,
    output logic               out_last,
    output logic [TAG_W-1:0]   out_tag
);

    logic [STATE_W-1:0] sr_state;
    logic [STATE_W-1:0] mc_state;
    logic [STATE_W-1:0] round_state;

    // ShiftRows: destination (r, c) takes source (r, (c + r) mod 4)
    for (genvar c = 0; c < 4; c++) begin : g_sr_col
        for (genvar r = 0; r < 4; r++) begin : g_sr_row
            localparam int DST = byte_msb(r, c);
            localparam int SRC = byte_msb(r, (c + r) % 4);
            assign sr_state[DST -: 8] = in_data[SRC -: 8];
        end
    end

    for (genvar c = 0; c < 4; c++) begin : g_mc
        mix_column u_mix_column (
            .col   (sr_state[127 - 32 * c -: 32]),
            .mixed (mc_state[127 - 32 * c -: 32])
        );
    end

    // Select the final-round bypass of MixColumns
    always_comb begin
        round_state = mc_state;
        if (in_last) begin
            round_state = sr_state;
        end else begin
            round_state = mc_state;
        end
    end

`ifdef MIXCOL_PIPE_EN

    logic               s1_valid;
    logic [STATE_W-1:0] s1_state;
    logic [127:0]       s1_key;
    logic               s1_last;
    logic [TAG_W-1:0]   s1_tag;
    logic               s2_ready;

    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    // Stage 1: hold the ShiftRows/MixColumns result and its key
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_state <= {STATE_W{1'b0}};
            s1_key   <= 128'h0;
            s1_last  <= 1'b0;
            s1_tag   <= {TAG_W{1'b0}};
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_state <= round_state;
                s1_key   <= in_key;
                s1_last  <= in_last;
                s1_tag   <= in_tag;
            end
        end
    end

    // Stage 2: AddRoundKey into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 128'h0;
            out_last  <= 1'b0;
            out_tag   <= {TAG_W{1'b0}};
        end else if (s2_ready) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= s1_state ^ s1_key;
                out_last <= s1_last;
                out_tag  <= s1_tag;
            end
        end
    end

`else

    // A full stage can still load when it is drained on the same edge
    assign in_ready = !out_valid || out_ready;

    // Single stage: AddRoundKey straight into the output register
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= 128'h0;
            out_last  <= 1'b0;
            out_tag   <= {TAG_W{1'b0}};
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= round_state ^ in_key;
                out_last <= in_last;
                out_tag  <= in_tag;
            end
        end
    end

`endif

endmodule

// File: tb/tb_aes_round_tail.sv
// tb_aes_round_tail
// Scoreboard bench for aes_round_tail: stimulus pushes expected beats into a
// queue when accepted; an independent monitor pops and compares on every
// output handshake. Directed FIPS-197 vectors plus a reference model for
// streaming, backpressure, reset and random handshake phases.
module tb_aes_round_tail;

    localparam int TAG_W = 4;
`ifdef MIXCOL_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    localparam logic [127:0] FIPS_IN  = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] FIPS_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_R1  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    localparam logic [127:0] FIPS_SR  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic [127:0]       in_data;
    logic [127:0]       in_key;
    logic               in_last;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [127:0]       out_data;
    logic               out_last;
    logic [TAG_W-1:0]   out_tag;

    typedef struct packed {
        logic [127:0]     data;
        logic             last;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur_exp;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int stream_pops = 0;
    int gaps = 0;
    int last_pop_cyc = 0;
    bit stream_chk = 1'b0;
    bit rand_done = 1'b0;

    logic               prev_valid = 1'b0;
    logic               prev_ready = 1'b0;
    logic               prev_rst = 1'b1;
    logic [127:0]       prev_data = 128'h0;
    logic               prev_last = 1'b0;
    logic [TAG_W-1:0]   prev_tag = '0;

    aes_round_tail #(.TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .in_last   (in_last),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_tag   (out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endfunction

    // Reference model: generic GF(2^8) multiply over an explicit 4x4 state
    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        logic hi;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
            b = {1'b0, b[7:1]};
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] d, input logic [127:0] k, input logic l);
        logic [7:0] s [4][4];
        logic [7:0] t [4][4];
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [127:0] res;
        coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = d[127 - 8 * (4 * c + r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r][c] = s[r][(c + r) % 4];
        res = 128'h0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (l) begin
                    acc = t[r][c];
                end else begin
                    acc = 8'h00;
                    for (int j = 0; j < 4; j++)
                        acc = acc ^ gmul(coef[(j - r + 4) % 4], t[j][c]);
                end
                res[127 - 8 * (4 * c + r) -: 8] = acc;
            end
        end
        return res ^ k;
    endfunction

    // Scoreboard push: record the expected result of every accepted beat
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else if (in_valid && in_ready) begin
            exp_q.push_back(cur_exp);
        end
    end

    // Monitor: compare each output handshake and watch stall behaviour
    always @(negedge clk) begin
        beat_t e;
        if (!rst && !prev_rst && prev_valid && !prev_ready) begin
            check("valid_hold", {127'h0, out_valid}, 128'h1);
            check("stall_data", out_data, prev_data);
            check("stall_tag", {{(128-TAG_W){1'b0}}, out_tag}, {{(128-TAG_W){1'b0}}, prev_tag});
            check("stall_last", {127'h0, out_last}, {127'h0, prev_last});
        end
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_beat: got tag %0d data %h, expected no beat", out_tag, out_data);
            end else begin
                e = exp_q.pop_front();
                check("data", out_data, e.data);
                check("last", {127'h0, out_last}, {127'h0, e.last});
                check("tag", {{(128-TAG_W){1'b0}}, out_tag}, {{(128-TAG_W){1'b0}}, e.tag});
            end
            if (stream_chk) begin
                if (stream_pops > 0 && cyc != last_pop_cyc + 1) gaps++;
                stream_pops++;
                last_pop_cyc = cyc;
            end
        end
        prev_valid = out_valid;
        prev_ready = out_ready;
        prev_rst   = rst;
        prev_data  = out_data;
        prev_last  = out_last;
        prev_tag   = out_tag;
    end

    task automatic present(input logic [127:0] d, input logic [127:0] k, input logic l,
                           input logic [TAG_W-1:0] t, input logic [127:0] e);
        in_data  = d;
        in_key   = k;
        in_last  = l;
        in_tag   = t;
        cur_exp  = '{data: e, last: l, tag: t};
        in_valid = 1'b1;
    endtask

    // Hold the presented beat until the edge that accepts it
    task automatic wait_accept();
        int n;
        bit acc;
        n = 0;
        forever begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            n++;
            if (n > 500) begin
                total++;
                bad++;
                $display("FAIL accept_timeout: got no acceptance after %0d cycles, expected acceptance", n);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic l,
                        input logic [TAG_W-1:0] t, input logic [127:0] e);
        present(d, k, l, t, e);
        wait_accept();
    endtask

    task automatic send_rand(input logic [TAG_W-1:0] t);
        logic [127:0] d, k;
        logic l;
        d = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        l = 1'($urandom_range(0, 1));
        send(d, k, l, t, ref_round(d, k, l));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int c0;
        logic [127:0] d, k, snap_data;
        logic [TAG_W-1:0] snap_tag;
        logic l;
        bit acc;
        int bi;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_data = 128'h0; in_key = 128'h0; in_last = 1'b0; in_tag = '0;
        cur_exp = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", {127'h0, out_valid}, 128'h0);
        check("rst_out_data", out_data, 128'h0);
        check("rst_out_last", {127'h0, out_last}, 128'h0);
        check("rst_out_tag", {{(128-TAG_W){1'b0}}, out_tag}, 128'h0);
        check("rst_in_ready", {127'h0, in_ready}, 128'h1);
        @(posedge clk); #1;

        // FIPS-197 round 1 and latency
        send(FIPS_IN, FIPS_KEY, 1'b0, 4'd1, FIPS_R1);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            @(posedge clk); @(negedge clk);
            n++;
        end
        check("latency", 128'(n + 1), 128'(LAT));
        @(posedge clk); #1;

        // Final round: ShiftRows only
        send(FIPS_IN, 128'h0, 1'b1, 4'd2, FIPS_SR);
        repeat (4) @(posedge clk); #1;

        // Streaming, 16 back-to-back beats
        stream_chk = 1'b1;
        c0 = cyc;
        for (int i = 0; i < 16; i++) send_rand(TAG_W'(i));
        check("stream_cycles", 128'(cyc - c0), 128'd16);
        repeat (LAT + 2) @(posedge clk); #1;
        stream_chk = 1'b0;
        check("stream_count", 128'(stream_pops), 128'd16);
        check("stream_gaps", 128'(gaps), 128'd0);

        // Backpressure: out_ready low for 5 cycles
        out_ready = 1'b0;
        bi = 0;
        d = {$urandom, $urandom, $urandom, $urandom};
        k = {$urandom, $urandom, $urandom, $urandom};
        present(d, k, 1'b0, 4'd8, ref_round(d, k, 1'b0));
        snap_data = 128'h0;
        snap_tag = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            acc = in_ready;
            if (c == LAT) begin
                snap_data = out_data;
                snap_tag = out_tag;
            end
            if (c > LAT) begin
                check("bp_data_stable", out_data, snap_data);
                check("bp_tag_stable", {{(128-TAG_W){1'b0}}, out_tag}, {{(128-TAG_W){1'b0}}, snap_tag});
            end
            if (c == 4) check("bp_in_ready_low", {127'h0, in_ready}, 128'h0);
            @(posedge clk); #1;
            if (acc) begin
                bi++;
                d = {$urandom, $urandom, $urandom, $urandom};
                k = {$urandom, $urandom, $urandom, $urandom};
                present(d, k, 1'b1, TAG_W'(8 + bi), ref_round(d, k, 1'b1));
            end
        end
        check("bp_accepted", 128'(bi), 128'(LAT));
        out_ready = 1'b1;
        wait_accept();
        for (int i = 0; i < 3; i++) send_rand(TAG_W'(12 + i));
        repeat (LAT + 3) @(posedge clk); #1;
        check("bp_drained", 128'(exp_q.size()), 128'd0);

        // Reset with beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < LAT; i++) send_rand(4'd6);
        d = {$urandom, $urandom, $urandom, $urandom};
        present(d, d, 1'b0, 4'd7, ref_round(d, d, 1'b0));
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", {127'h0, out_valid}, 128'h0);
        check("midrst_in_ready", {127'h0, in_ready}, 128'h1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(FIPS_IN, FIPS_KEY, 1'b0, 4'd5, FIPS_R1);
        repeat (LAT + 3) @(posedge clk); #1;
        check("midrst_drained", 128'(exp_q.size()), 128'd0);

        // Random valid/ready toggling
        fork
            begin
                for (int i = 0; i < 10000; i++) begin
                    while ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send_rand(TAG_W'($urandom_range(0, 15)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        repeat (10) @(posedge clk); #1;
        check("final_queue_empty", 128'(exp_q.size()), 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes_round_tail.md
# aes_round_tail

Registered AES-128 round tail: consumes the 128-bit SubBytes output of the current round and applies ShiftRows, MixColumns (bypassed on the final round) and AddRoundKey. The result goes to the round register / next SubBytes, or to the ciphertext output. Input and output use valid/ready handshakes with full throughput, so the block can sit in an unrolled pipeline or an iterative round loop.

## Interface
Parameters:
- TAG_W, 4, width of the sideband tag carried alongside each block (round number or stream ID)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block accepts input this cycle
- in_data  in  128  SubBytes output; byte k = in_data[127-8k -: 8], state row k%4, column k/4
- in_key  in  128  round key, same byte order, sampled with in_data
- in_last  in  1  final round: bypass MixColumns
- in_tag  in  TAG_W  sideband, passed through unchanged
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts output
- out_data  out  128  round result, same byte order
- out_last  out  1  in_last of the beat
- out_tag  out  TAG_W  in_tag of the beat

## Operation
- Transfer occurs on a clock edge where valid && ready, independently on each side.
- ShiftRows: row r rotates left by r byte positions (row 0 unchanged).
- MixColumns: per column, GF(2^8) multiply by {02,03,01,01} circulant, reduction polynomial 0x11B.
  - xtime(b) = (b<<1) ^ (b[7] ? 0x1B : 0).
- in_last=1: MixColumns output replaced by ShiftRows output.
- out_data = (in_last ? SR(in_data) : MC(SR(in_data))) ^ in_key.
- Combinational logic is all in front of the output register; outputs are driven directly from flops.
- Each pipeline stage holds one beat with a valid bit.
- A stage loads when it is empty or is being drained in the same cycle: in_ready = !stage_valid || out_ready (single-stage case).
- No beat is ever dropped, duplicated or reordered.
- in_data, in_key, in_last and in_tag do not need to be held after acceptance.

## Timing
- Latency: 1 cycle, accept edge to out_valid (2 cycles with MIXCOL_PIPE_EN).
- Throughput: 1 beat/cycle while out_ready=1.
- Reset values:
  - out_valid=0, out_data=0, out_last=0, out_tag=0.
  - in_ready=1 in the first cycle after reset is released.
  - All internal stage valids = 0.
- Reset mid-operation: every in-flight beat is discarded and no output handshake completes on the reset edge.
- Backpressure, out_ready=0 with output full:
  - out_* stay stable.
  - in_ready=0 once all stages are full.
- Simultaneous accept and drain on a full stage: the new beat replaces the old one on the same edge with no bubble.
- out_valid never drops without a handshake.
- in_ready may depend combinationally on out_ready. No other combinational path runs from input to output.

## Configuration
- MIXCOL_PIPE_EN defined:
  - Adds a register stage after ShiftRows/MixColumns; AddRoundKey is computed in stage 2.
  - in_key is carried through stage 1.
  - Latency 2, still 1 beat/cycle.
  - in_ready = !s1_valid || (!s2_valid || out_ready).
  - Holds up to 2 beats.
- Undefined: single stage as described above, latency 1, holds 1 beat.

## Structure
- Shared package aes_pkg:
  - STATE_W=128 and RED_POLY=8'h1B.
  - Function xtime.
  - Byte-index helper for row/column addressing.
- One sub-module, mix_column: combinational, 32-bit column in, 32-bit column out. Instantiated 4 times.
- ShiftRows is pure wiring, not a module.

## Test plan
- FIPS-197 App. B round 1, in_last=0:
  - Stimulus: in_data=d42711aee0bf98f1b8b45de51e415230, in_key=a0fafe1788542cb123a339392a6c7605.
  - Response: out_data=a49c7ff2689f352b6b5bea43026a5049 after 1 cycle (2 with MIXCOL_PIPE_EN).
- Final round, in_last=1:
  - Stimulus: same in_data, in_key=0.
  - Response: out_data=d4bf5d30e0b452aeb84111f11e2798e5 (ShiftRows only).
- Streaming: 16 back-to-back beats with tags 0..15 and out_ready=1.
  - One output per cycle, tags in order, no bubbles.
  - Each data value matches the software model.
- Backpressure: hold out_ready=0 for 5 cycles mid-stream.
  - in_ready falls once stages are full.
  - out_data and out_tag stay stable.
  - On release, all beats arrive in order with no loss or duplication.
- Reset mid-stream: assert rst for 1 cycle with 2 beats in flight.
  - out_valid=0 the next cycle.
  - The discarded beats never appear.
  - The next accepted beat produces correct data.
- Random valid/ready toggling, 10k beats: scoreboard against the reference model for data, last and tag.
